// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared constants and next-PC source encoding for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int          PC_XLEN_DEFAULT         = 32;
    localparam int          PC_STEP_DEFAULT         = 4;
    localparam int          PC_RAS_DEPTH_DEFAULT    = 4;
    localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Source selected for the value pc takes at the next edge
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_LOAD  = 3'd2,
        SEL_RET   = 3'd3,
        SEL_TRAP  = 3'd4,
        SEL_RESET = 3'd5
    } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Return-address stack with circular storage. A push onto a
//               full stack overwrites the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int XLEN      = PC_XLEN_DEFAULT,
    parameter int RAS_DEPTH = PC_RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(RAS_DEPTH);

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   r_ptr;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_empty;
    logic               r_full;

    logic [PTR_W-1:0]   w_ptr_next;
    logic [DEPTH_W-1:0] w_depth_next;

    // Pointer/depth update; push saturates depth, pop on empty is a no-op
    always_comb begin
        w_ptr_next   = r_ptr;
        w_depth_next = r_depth;
        if (push) begin
            w_ptr_next = r_ptr + PTR_W'(1);
            if (r_depth != c_max_depth) begin
                w_depth_next = r_depth + DEPTH_W'(1);
            end
        end else if (pop && (r_depth != '0)) begin
            w_ptr_next   = r_ptr - PTR_W'(1);
            w_depth_next = r_depth - DEPTH_W'(1);
        end
    end

    // Pointer, depth and registered occupancy flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_depth <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_next;
            r_depth <= w_depth_next;
            r_empty <= (w_depth_next == '0);
            r_full  <= (w_depth_next == c_max_depth);
        end
    end

    // Entry storage; contents are unreachable while empty so never cleared
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push) begin
                r_mem[w_ptr_next] <= push_data;
            end else if (replace) begin
                r_mem[r_ptr] <= push_data;
            end
        end
    end

    assign top   = r_mem[r_ptr];
    assign empty = r_empty;
    assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with trap/stall/ret/load/increment priority,
//               call/return stack and target alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
    parameter int              STEP         = PC_STEP_DEFAULT,
    parameter int              RAS_DEPTH    = PC_RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            increment,
    input  logic            load,
    input  logic [XLEN-1:0] load_addr,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] c_step       = XLEN'(STEP);
    localparam logic [XLEN-1:0] c_align_mask = XLEN'(STEP - 1);

    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_ras_top;
    logic [XLEN-1:0] w_ret_target;
    logic [XLEN-1:0] w_pc_next;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_trap_ok;
    logic            w_load_ok;
    logic            w_ret_ok;
    logic            w_push;
    logic            w_pop;
    logic            w_replace;
    logic            w_reject;
    pc_sel_t         w_sel;

    assign w_pc_inc     = r_pc + c_step;
    assign w_ret_target = w_ras_empty ? load_addr : w_ras_top;
    assign w_trap_ok    = (trap_vector  & c_align_mask) == '0;
    assign w_load_ok    = (load_addr    & c_align_mask) == '0;
    assign w_ret_ok     = (w_ret_target & c_align_mask) == '0;

    // Request arbitration: pick the PC source and the stack operation
    always_comb begin
        w_sel     = SEL_HOLD;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_replace = 1'b0;
        w_reject  = 1'b0;
        if (reset) begin
            w_sel = SEL_RESET;
        end else if (trap) begin
            if (w_trap_ok) w_sel = SEL_TRAP;
            else           w_reject = 1'b1;
        end else if (stall) begin
            w_sel = SEL_HOLD;
        end else if (ret) begin
            if (w_ret_ok) begin
                w_sel = SEL_RET;
                if (call) begin
                    // Call+ret swaps the top entry, or pushes onto an empty stack
                    w_push    = w_ras_empty;
                    w_replace = !w_ras_empty;
                end else begin
                    w_pop = !w_ras_empty;
                end
            end else begin
                w_reject = 1'b1;
            end
        end else if (load) begin
            if (w_load_ok) begin
                w_sel  = SEL_LOAD;
                w_push = call;
            end else begin
                w_reject = 1'b1;
            end
        end else if (increment) begin
            w_sel = SEL_INC;
        end
    end

    // Next-PC multiplexer
    always_comb begin
        case (w_sel)
            SEL_RESET: w_pc_next = RESET_VECTOR;
            SEL_TRAP:  w_pc_next = trap_vector;
            SEL_RET:   w_pc_next = w_ret_target;
            SEL_LOAD:  w_pc_next = load_addr;
            SEL_INC:   w_pc_next = w_pc_inc;
            default:   w_pc_next = r_pc;
        endcase
    end

    // PC and misalignment pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_misaligned <= w_reject;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .replace   (w_replace),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign pc         = r_pc;
    assign pc_next    = w_pc_next;
    assign ras_empty  = w_ras_empty;
    assign ras_full   = w_ras_full;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit: directed scenarios followed
//               by random requests, compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        increment = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_addr = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        ras_empty;
    logic        ras_full;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_pc  = 32'h0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras [$];

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .increment   (increment),
        .load        (load),
        .load_addr   (load_addr),
        .call        (call),
        .ret         (ret),
        .trap        (trap),
        .trap_vector (trap_vector),
        .pc          (pc),
        .pc_next     (pc_next),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: model the request, check pc_next before the
    // edge, then check registered outputs after it.
    task automatic step(input string tag, input logic r, input logic tp, input logic st,
                        input logic inc, input logic ld, input logic cl, input logic rt,
                        input logic [31:0] la, input logic [31:0] tv);
        logic [31:0] q [$];
        logic [31:0] nxt;
        logic [31:0] tgt;
        logic        mis;
        reset = r; trap = tp; stall = st; increment = inc;
        load = ld; call = cl; ret = rt; load_addr = la; trap_vector = tv;
        q   = m_ras;
        nxt = m_pc;
        mis = 1'b0;
        if (r) begin
            nxt = 32'h0;
            q.delete();
        end else if (tp) begin
            if (tv % 4 == 0) nxt = tv;
            else             mis = 1'b1;
        end else if (st) begin
            nxt = m_pc;
        end else if (rt) begin
            tgt = (q.size() == 0) ? la : q[q.size()-1];
            if (tgt % 4 != 0) begin
                mis = 1'b1;
            end else begin
                nxt = tgt;
                if (cl) begin
                    if (q.size() == 0) q.push_back(m_pc + 32'd4);
                    else               q[q.size()-1] = m_pc + 32'd4;
                end else if (q.size() != 0) begin
                    void'(q.pop_back());
                end
            end
        end else if (ld) begin
            if (la % 4 != 0) begin
                mis = 1'b1;
            end else begin
                nxt = la;
                if (cl) begin
                    q.push_back(m_pc + 32'd4);
                    if (q.size() > DEPTH) void'(q.pop_front());
                end
            end
        end else if (inc) begin
            nxt = m_pc + 32'd4;
        end
        #1;
        checks++;
        assert (pc_next === nxt) else begin
            failures++;
            $error("FAIL %s pc_next observed=%h expected=%h", tag, pc_next, nxt);
        end
        @(posedge clk);
        #1;
        m_pc  = nxt;
        m_mis = mis;
        m_ras = q;
        checks++;
        assert (pc === m_pc) else begin
            failures++;
            $error("FAIL %s pc observed=%h expected=%h", tag, pc, m_pc);
        end
        checks++;
        assert (ras_empty === (m_ras.size() == 0)) else begin
            failures++;
            $error("FAIL %s ras_empty observed=%b expected=%b", tag, ras_empty, m_ras.size() == 0);
        end
        checks++;
        assert (ras_full === (m_ras.size() == DEPTH)) else begin
            failures++;
            $error("FAIL %s ras_full observed=%b expected=%b", tag, ras_full, m_ras.size() == DEPTH);
        end
        checks++;
        assert (misaligned === m_mis) else begin
            failures++;
            $error("FAIL %s misaligned observed=%b expected=%b", tag, misaligned, m_mis);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        // Reset and sequential increments
        step("reset",     1,0,0,0,0,0,0, 32'h0, 32'h0);
        step("inc1",      0,0,0,1,0,0,0, 32'h0, 32'h0);
        step("inc2",      0,0,0,1,0,0,0, 32'h0, 32'h0);
        step("inc3",      0,0,0,1,0,0,0, 32'h0, 32'h0);
        // Wrap at the top of the address space
        step("ld_top",    0,0,0,0,1,0,0, 32'hFFFF_FFFC, 32'h0);
        step("wrap",      0,0,0,1,0,0,0, 32'h0, 32'h0);
        // Call and return
        step("ld_100",    0,0,0,0,1,0,0, 32'h100, 32'h0);
        step("call_200",  0,0,0,0,1,1,0, 32'h200, 32'h0);
        step("ret_104",   0,0,0,0,0,0,1, 32'h0, 32'h0);
        // Overflowing the stack, then draining it
        step("ld_10",     0,0,0,0,1,0,0, 32'h10, 32'h0);
        for (int i = 0; i < 5; i++) begin
            a = 32'h20 + 32'(i) * 32'h10;
            step("call_chain", 0,0,0,0,1,1,0, a, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step("ret_chain", 0,0,0,0,0,0,1, 32'h400, 32'h0);
        end
        step("ret_empty", 0,0,0,0,0,0,1, 32'h400, 32'h0);
        // Misaligned load rejected, pulse lasts one cycle
        step("ld_202",    0,0,0,0,1,0,0, 32'h202, 32'h0);
        step("after_mis", 0,0,0,0,0,0,0, 32'h0, 32'h0);
        // Stall holds, trap overrides stall
        step("stall",     0,0,1,1,1,0,0, 32'h300, 32'h0);
        step("stall_trap",0,1,1,0,0,0,0, 32'h0, 32'h80);
        step("trap_mis",  0,1,0,0,0,0,0, 32'h0, 32'h81);
        // Call+ret swaps top; then reset in the middle of a call
        step("call_a",    0,0,0,0,1,1,0, 32'h500, 32'h0);
        step("callret",   0,0,0,0,1,1,1, 32'h600, 32'h0);
        step("rst_call",  1,0,0,0,1,1,0, 32'h700, 32'h0);
        step("callret_e", 0,0,0,0,0,1,1, 32'h800, 32'h0);
        // Random requests against the model
        for (int i = 0; i < 600; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            v = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) v[1:0] = 2'($urandom_range(1, 3));
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0), a, v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 Parameter STEP, default 4, sequential increment in bytes; power of two, at least 1.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC; suppresses increment, load, call and ret.
REQ-008 increment  in  1  advance PC by STEP.
REQ-009 load  in  1  jump/branch: PC takes load_addr.
REQ-010 load_addr  in  XLEN  jump/branch target; also the ret fallback target.
REQ-011 call  in  1  with load: push PC+STEP onto the RAS.
REQ-012 ret  in  1  return: PC takes the RAS top, or load_addr if the RAS is empty.
REQ-013 trap  in  1  PC takes trap_vector; overrides stall.
REQ-014 trap_vector  in  XLEN  trap target.
REQ-015 pc  out  XLEN  registered current PC.
REQ-016 pc_next  out  XLEN  combinational value pc takes at next edge.
REQ-017 ras_empty / ras_full  out  1 each  registered RAS occupancy flags.
REQ-018 misaligned  out  1  registered; one-cycle pulse on a rejected target.

Function
REQ-019 Priority per edge: reset > trap > stall > ret > load > increment > hold.
REQ-020 increment: pc <= pc + STEP modulo 2^XLEN; pc = 2^XLEN-STEP wraps to 0.
REQ-021 load (no ret): pc <= load_addr; with call, also push pc+STEP (mod 2^XLEN).
REQ-022 ret, RAS non-empty: pc <= top entry; pop.
REQ-023 ret, RAS empty: pc <= load_addr; no pop; RAS unchanged.
REQ-024 ret with call, RAS non-empty: pc <= old top; top entry overwritten with pc+STEP; depth unchanged.
REQ-025 ret with call, RAS empty: pc <= load_addr; push pc+STEP.
REQ-026 call without load or ret is ignored.
REQ-027 Push when full: oldest entry discarded (circular overwrite); ras_full stays 1; new top is the pushed value.
REQ-028 Target alignment: load, ret or trap target with addr mod STEP != 0 is rejected.
REQ-029 On rejection: pc holds, the RAS is unchanged, and misaligned = 1 on the next cycle only.
REQ-030 misaligned = 0 on every other cycle.
REQ-031 stall=1 without trap: pc, the RAS and flags hold; misaligned = 0.
REQ-032 trap leaves the RAS untouched.
REQ-033 pc_next equals the value pc takes at the next edge, including reset (RESET_VECTOR) and rejections (pc).
REQ-034 Latency: every accepted request is visible on pc one cycle after the edge.

Reset
REQ-035 On reset: pc = RESET_VECTOR, RAS depth = 0, ras_empty = 1, ras_full = 0, misaligned = 0.
REQ-036 Reset mid-operation wins over all simultaneous requests; no push or pop occurs that cycle.
REQ-037 RAS entry contents need not be cleared; they are unreachable while empty.

Structure
REQ-038 Shared package holds XLEN default, STEP default and the RESET_VECTOR default constant.
REQ-039 The RAS is one sub-module, pc_ras, parameterised by XLEN and RAS_DEPTH.
REQ-040 pc_ras ports: push, pop, replace, push_data, top, empty, full.
REQ-041 pc_ras uses a circular pointer and a depth counter 0..RAS_DEPTH.

Verification
REQ-042 Reset, then increment x3 (STEP=4, RESET_VECTOR=0) -> pc 4, 8, 12; pc_next leads pc by one cycle.
REQ-043 pc=0xFFFFFFFC, increment -> pc=0x00000000.
REQ-044 pc=0x100; load+call to 0x200; then ret -> pc 0x200, then 0x104; ras_empty back to 1.
REQ-045 Five calls with RAS_DEPTH=4 (from 0x10, 0x20, 0x30, 0x40, 0x50) -> ras_full=1; four rets return 0x54, 0x44, 0x34, 0x24; a fifth ret returns load_addr.
REQ-046 load to 0x202 -> pc unchanged, misaligned pulses once.
REQ-047 stall with trap to 0x80 -> pc=0x80.
REQ-048 reset during load+call -> pc=RESET_VECTOR, ras_empty=1.
